// File: rtl/mips_pkg.sv
// mips_pkg: shared datapath widths, register indices and ALU control encodings
package mips_pkg;
    localparam int WIDTH      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctrl_e;
endpackage

// File: rtl/reg_file.sv
// reg_file: MIPS register file, two async read ports, one sync write port, r0 reads zero
//   clk/rst             : clock, synchronous active-high reset clearing all registers
//   rd_addr1/rd_data1   : read port 1 (ALU op1)
//   rd_addr2/rd_data2   : read port 2 (ALU op2 / store data)
//   we/wr_addr/wr_data  : write port, writes to index 0 are dropped
//   dbg_addr/dbg_data   : debug read port
module reg_file
    import mips_pkg::*;
#(
    parameter int WIDTH = mips_pkg::WIDTH,
    parameter int DEPTH = REG_COUNT,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [WIDTH-1:0]  rd_data1,
    output logic [WIDTH-1:0]  rd_data2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]  dbg_data
);
    logic [WIDTH-1:0] regs_q [1:DEPTH-1];
    logic [WIDTH-1:0] regs_d [1:DEPTH-1];

    always_comb begin
        regs_d = regs_q;
        if (we && wr_addr != '0) regs_d[wr_addr] = wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // No write-through bypass: wr_data depends on rd_data through the ALU.
    assign rd_data1 = (rd_addr1 == '0) ? '0 : regs_q[rd_addr1];
    assign rd_data2 = (rd_addr2 == '0) ? '0 : regs_q[rd_addr2];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: randomized and directed checks of reg_file against an array model
module tb_reg_file;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  rd_addr1 = '0;
    logic [4:0]  rd_addr2 = '0;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        we = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [32];

    reg_file dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : model[a];
    endfunction

    task automatic step();
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we && wr_addr != 5'd0) begin
            model[wr_addr] = wr_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        write_reg(5'd5, 32'hDEADBEEF);
        rd_addr1 = 5'd5;
        #1;
        checks++;
        if (rd_data1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL reset_preload got %h want %h", rd_data1, 32'hDEADBEEF);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (rd_data1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_r5 got %h want %h", rd_data1, 32'h0);
        end
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            checks++;
            if (dbg_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_sweep r%0d got %h want %h", i, dbg_data, 32'h0);
            end
        end
    endtask

    task automatic test_write_read();
        we = 1'b1;
        wr_addr = 5'd7;
        wr_data = 32'h12345678;
        rd_addr2 = 5'd7;
        #1;
        checks++;
        if (rd_data2 !== 32'h0) begin
            errors++;
            $display("FAIL write_before_edge got %h want %h", rd_data2, 32'h0);
        end
        step();
        we = 1'b0;
        rd_addr1 = 5'd7;
        #1;
        checks++;
        if (rd_data2 !== 32'h12345678) begin
            errors++;
            $display("FAIL write_after_edge_p2 got %h want %h", rd_data2, 32'h12345678);
        end
        checks++;
        if (rd_data1 !== 32'h12345678) begin
            errors++;
            $display("FAIL write_after_edge_p1 got %h want %h", rd_data1, 32'h12345678);
        end
    endtask

    task automatic test_zero_reg();
        write_reg(REG_ZERO, 32'hFFFFFFFF);
        rd_addr1 = REG_ZERO;
        dbg_addr = REG_ZERO;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (rd_data1 !== 32'h0 || dbg_data !== 32'h0) begin
                errors++;
                $display("FAIL zero_reg cycle %0d got %h/%h want %h", c, rd_data1, dbg_data, 32'h0);
            end
            step();
        end
    endtask

    task automatic test_read_during_write();
        write_reg(5'd3, 32'h00000010);
        rd_addr1 = 5'd3;
        rd_addr2 = 5'd3;
        we = 1'b1;
        wr_addr = 5'd3;
        wr_data = 32'h00000020;
        #1;
        checks++;
        if (rd_data1 !== 32'h00000010 || rd_data2 !== 32'h00000010) begin
            errors++;
            $display("FAIL rdw_same_cycle got %h/%h want %h", rd_data1, rd_data2, 32'h10);
        end
        step();
        we = 1'b0;
        #1;
        checks++;
        if (rd_data1 !== 32'h00000020) begin
            errors++;
            $display("FAIL rdw_next_cycle got %h want %h", rd_data1, 32'h20);
        end
    endtask

    task automatic test_reset_priority();
        write_reg(5'd9, 32'h11111111);
        rst = 1'b1;
        we = 1'b1;
        wr_addr = 5'd9;
        wr_data = 32'hA5A5A5A5;
        step();
        rst = 1'b0;
        we = 1'b0;
        dbg_addr = 5'd9;
        #1;
        checks++;
        if (dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_priority got %h want %h", dbg_data, 32'h0);
        end
    endtask

    task automatic test_sweep_hold();
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i) * 32'h01010101);
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i);
            rd_addr2 = 5'(31 - i);
            #1;
            checks++;
            if (rd_data1 !== 32'(i) * 32'h01010101) begin
                errors++;
                $display("FAIL sweep_p1 r%0d got %h want %h", i, rd_data1, 32'(i) * 32'h01010101);
            end
            checks++;
            if (rd_data2 !== 32'(31 - i) * 32'h01010101) begin
                errors++;
                $display("FAIL sweep_p2 r%0d got %h want %h", 31 - i, rd_data2, 32'(31 - i) * 32'h01010101);
            end
        end
        we = 1'b0;
        for (int c = 0; c < 10; c++) begin
            wr_addr = 5'($urandom_range(0, 31));
            wr_data = $urandom;
            step();
        end
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            checks++;
            if (dbg_data !== 32'(i) * 32'h01010101) begin
                errors++;
                $display("FAIL hold r%0d got %h want %h", i, dbg_data, 32'(i) * 32'h01010101);
            end
        end
    endtask

    task automatic test_random();
        write_reg(REG_SP, 32'h7FFFEFFC);
        write_reg(REG_RA, 32'h00400018);
        for (int c = 0; c < 300; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            we = $urandom_range(0, 1) == 1;
            wr_addr = 5'($urandom_range(0, 31));
            wr_data = $urandom;
            rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rd_addr2 = 5'($urandom_range(0, 31));
            dbg_addr = 5'($urandom_range(0, 31));
            #1;
            checks++;
            if (rd_data1 !== ref_rd(rd_addr1) || rd_data2 !== ref_rd(rd_addr2) || dbg_data !== ref_rd(dbg_addr)) begin
                errors++;
                $display("FAIL random cycle %0d got %h/%h/%h want %h/%h/%h", c,
                         rd_data1, rd_data2, dbg_data,
                         ref_rd(rd_addr1), ref_rd(rd_addr2), ref_rd(dbg_addr));
            end
            step();
        end
        rst = 1'b0;
        we = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_read_during_write();
        test_reset_priority();
        test_sweep_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural general-purpose register file of the single-cycle MIPS datapath.
- Sits directly upstream of the ALU.
  - Read port 1 supplies op1.
  - Read port 2 supplies op2, or the store data when the immediate is muxed in.
  - The write port takes the writeback value: ALU result or memory load data.
- Two asynchronous read ports and one synchronous write port. Register 0 is hardwired to zero.

Parameters:
- WIDTH, 32, data width of each register; must match the ALU width.
- DEPTH, 32, number of registers; must be a power of two.
- ADDR_W, 5, register index width; equals log2(DEPTH). It is a localparam derived from DEPTH and is not overridable.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset; clears every register.
- rd_addr1  input  ADDR_W  read port 1 index (rs field).
- rd_addr2  input  ADDR_W  read port 2 index (rt field).
- rd_data1  output  WIDTH  contents of register rd_addr1; drives ALU op1.
- rd_data2  output  WIDTH  contents of register rd_addr2; drives ALU op2 / store data.
- we  input  1  write enable (RegWrite from the main control).
- wr_addr  input  ADDR_W  write index (rt or rd, selected by RegDst upstream).
- wr_data  input  WIDTH  write data (ALU result or load data).
- dbg_addr  input  ADDR_W  bench/debug read index; has no functional use.
- dbg_data  output  WIDTH  contents of register dbg_addr.

Behaviour:
- Clocking and reset
  - Single clock domain: clk.
  - rst is synchronous and active-high, sampled on the rising edge of clk.
  - On a rising edge with rst=1, all DEPTH registers load 0. rst has priority over we, so a write presented in the reset cycle is discarded.
  - No output register exists. rd_data1, rd_data2 and dbg_data read 0 for any address from the first edge after rst is asserted.
- Reads
  - Combinational, with zero-cycle latency from address to data.
  - rd_addr==0 always returns 0, regardless of storage contents.
- Writes
  - Take effect on the rising edge of clk when rst=0, we=1 and wr_addr!=0.
  - The new value is visible on the read ports after that edge.
- Writes to register 0
  - Silently ignored; the storage for index 0 is never updated (or is not implemented).
  - No error flag is raised.
- Read-during-write to the same index
  - The read returns the OLD value for the whole cycle.
  - There is deliberately no write-through bypass. In the single-cycle datapath, wr_data depends combinationally on rd_data through the ALU, so a bypass would create a combinational loop. Example: add $1,$1,$1.
- Both read ports may address the same register, or the register being written, in the same cycle. No conflict results and there is no stall logic.
- we=0: storage is unchanged; wr_addr and wr_data are don't-care.
- X/unknown addresses need no defined handling.
- State
  - DEPTH-1 registers of WIDTH bits.
  - No FSM; the sequential behaviour is purely the write/reset update.
- Width rules: no arithmetic in this block; data passes through unmodified and unextended.

Decomposition:
- Shared package mips_pkg holds:
  - WIDTH=32
  - REG_ADDR_W=5
  - REG_COUNT=32
  - REG_ZERO=5'd0
  - Named indices used by benches: REG_SP=29, REG_RA=31.
- The package also holds the ALU control encodings, so the control and regfile benches share one source.
- No sub-module. The decode/storage/read-mux logic is a single module. A per-register cell would only add hierarchy.

Test Plan:
1. Reset clear: preload r5=0xDEADBEEF, then assert rst for one edge -> rd_data1 (rd_addr1=5) = 0x00000000 after the edge; all 32 registers read 0 via dbg_addr sweep.
2. Write/read: we=1, wr_addr=7, wr_data=0x12345678 -> before the edge rd_data2 (rd_addr2=7) shows the old value 0; after the edge it shows 0x12345678. Read both ports from index 7 simultaneously -> both show 0x12345678.
3. Zero register: we=1, wr_addr=0, wr_data=0xFFFFFFFF -> rd_data1 with rd_addr1=0 stays 0x00000000 on all following cycles.
4. Read-during-write: r3=0x00000010; in the same cycle rd_addr1=3, we=1, wr_addr=3, wr_data=0x00000020 -> rd_data1=0x00000010 for that cycle and 0x00000020 the next cycle.
5. Reset priority: rst=1, we=1, wr_addr=9, wr_data=0xA5A5A5A5 on the same edge -> r9 reads 0x00000000 afterwards.
6. Write disabled and full sweep:
   - Write index i with value i*0x01010101 for i=1..31, then read all registers on both ports -> exact values returned.
   - Then hold we=0 with changing wr_addr/wr_data for 10 cycles -> no register changes.
